rpn_eval: RTL and testbench
===========================

// Module: rpn_eval
// PURPOSE
//   Reverse-Polish evaluator that drives an external lifo stack (push/pop/full/empty port set).
//   Accepts a valid/ready token stream of operands and opcodes. Pushes operands, pops two and
//   pushes one per binary op, and pops the final result on EQ. Sits directly upstream of the
//   lifo and also consumes its dout: the stack's sole master.
// PARAMETERS
//   N      32  datapath / stack word width; must match the lifo N
//   depth  3   log2 of stack entries; must match the lifo depth (8 entries)
// PORTS
//   clk        in   1        single clock, rising edge
//   reset_n    in   1        asynchronous, active-low reset; lifo reset must be tied to ~reset_n
//   tok_valid  in   1        token present
//   tok_ready  out  1        block can accept a token
//   tok_is_op  in   1        1 = opcode in tok_data[3:0]; 0 = operand
//   tok_data   in   N        operand value or opcode
//   res_valid  out  1        one-cycle pulse: result on res_data
//   res_data   out  N        EQ result
//   err_code   out  2        0 none, 1 underflow, 2 overflow, 3 bad opcode (sticky)
//   err_clr    in   1        leave ERR state and flush the stack
//   level      out  depth+1  mirrored stack occupancy, 0..2**depth
//   stk_wr_en  out  1        lifo push
//   stk_rd_en  out  1        lifo pop
//   stk_din    out  N        lifo push data
//   stk_dout   in   N        lifo registered pop data, valid the cycle after stk_rd_en
//   stk_full   in   1        lifo full
//   stk_empty  in   1        lifo empty
// BEHAVIOUR
//   Reset (async, reset_n=0):
//     state=IDLE, level=0, err_code=0, res_valid=0, res_data=0, b_reg=0.
//     stk_wr_en=stk_rd_en=0. tok_ready=1 once reset is released.
//   Transfer occurs when tok_valid&&tok_ready. tok_ready=1 only in IDLE and ERR.
//   Opcodes: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 MUL, 6 EQ, others bad.
//     A is the deeper operand, B the top. Results are truncated to N bits; no carry or overflow flag.
//   States and transitions:
//     IDLE, operand: push same cycle (stk_wr_en=1, stk_din=tok_data), level+1.
//       If level==2**depth: no push, err_code=2, go to ERR.
//     IDLE, binary op: needs level>=2, else err_code=1, go to ERR.
//       Otherwise stk_rd_en=1, go to POP_A.
//     POP_A: b_reg<=stk_dout, stk_rd_en=1, go to EXEC.
//     EXEC: stk_wr_en=1, stk_din=alu(stk_dout,b_reg), go to IDLE. Net level -1.
//       Binary op latency is 3 cycles, accept to IDLE.
//     IDLE, EQ: needs level>=1, else underflow. Otherwise stk_rd_en=1, go to EQ_OUT.
//     EQ_OUT: res_valid=1, res_data<=stk_dout, level-1, go to IDLE.
//     IDLE, bad opcode: err_code=3, go to ERR. The stack is untouched.
//     ERR: tokens are accepted and discarded. err_clr=1: err_code stays, go to FLUSH.
//     FLUSH: stk_rd_en=1 while level>0, decrementing level. At level==0: err_code=0, go to IDLE.
//   Level tracking: level is the authoritative occupancy; stk_full/stk_empty are cross-checks only.
//     A mismatch (stk_full && level!=2**depth) is a verification assertion, not a runtime error.
//   Never asserts stk_wr_en and stk_rd_en in the same cycle. The lifo replace path is unused.
//   err_clr outside ERR is ignored. Reset mid-operation aborts at once; the lifo resets together with it.
// CONFIGURATION
//   Macro RPN_MUL_EN:
//     Defined: opcode 5 = A*B, low N bits, single-cycle combinational multiply in EXEC.
//     Undefined: opcode 5 is a bad opcode (err_code=3) and no multiplier is synthesised.
// STRUCTURE
//   Package rpn_pkg: opcode localparams, the state encoding
//     (IDLE, POP_A, EXEC, EQ_OUT, ERR, FLUSH), and the err_code values.
//   Sub-module rpn_alu: combinational (op, a, b) -> y, width N.
//     Holds the RPN_MUL_EN branch.
//   rpn_eval holds the FSM, level counter and b_reg.
// TESTING
//   Bench instantiates rpn_eval + lifo (N=32, depth=3).
//   1. Push 7, push 5, SUB, EQ -> res_valid one cycle, res_data=2, level=0, err_code=0.
//   2. Push 3,4,ADD,2,XOR,EQ -> res_data=5. Binary op holds tok_ready low exactly 2 cycles.
//   3. Push 9 operands -> 9th: no stk_wr_en, err_code=2, level=8.
//      Then err_clr -> 8 consecutive pops, err_code=0, level=0, stk_empty=1.
//   4. Push 1, ADD -> err_code=1, no stack access. Tokens in ERR are discarded with no push.
//   5. Opcode 5 with 6,7: RPN_MUL_EN defined -> EQ gives 42. Undefined -> err_code=3.
//   6. Push 0xFFFFFFFF,1,ADD,EQ -> res_data=0 (wrap).
//      Assert reset_n low during POP_A -> all outputs at reset values, level=0 next cycle.

Source files
------------

// File: rtl/rpn_pkg.sv
// Shared opcode, state and error encodings for the RPN evaluator.
// RPN_MUL_EN: when defined, opcode 5 (MUL) is accepted as a binary op.
package rpn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POP_A,
    EXEC,
    EQ_OUT,
    ERR,
    FLUSH
  } state_t;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_MUL = 4'd5;
  localparam logic [3:0] OP_EQ  = 4'd6;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_UNDER = 2'd1;
  localparam logic [1:0] ERR_OVER  = 2'd2;
  localparam logic [1:0] ERR_BADOP = 2'd3;

  function automatic logic op_is_binary(input logic [3:0] op);
    logic ok;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: ok = 1'b1;
`ifdef RPN_MUL_EN
      OP_MUL: ok = 1'b1;
`endif
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/rpn_alu.sv
// Combinational two-operand ALU for the RPN evaluator (y = A op B, truncated to N bits).
// Latency: zero cycles. Backpressure: none. MUL exists only when RPN_MUL_EN is defined.
module rpn_alu #(
  parameter int N = 32
) (
  input  logic [3:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] y
);
  import rpn_pkg::*;

  always_comb begin
    y = '0;
    case (op)
      OP_ADD: y = a + b;
      OP_SUB: y = a - b;
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
`ifdef RPN_MUL_EN
      OP_MUL: y = a * b;
`endif
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/rpn_eval.sv
// RPN evaluator driving an external lifo; binary op 3 cycles accept-to-ready, EQ result 2 cycles after accept.
// Backpressure: tok_ready drops while an op or flush owns the stack. RPN_MUL_EN enables opcode 5.
module rpn_eval #(
  parameter int N     = 32,
  parameter int depth = 3
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           tok_valid,
  output logic           tok_ready,
  input  logic           tok_is_op,
  input  logic [N-1:0]   tok_data,
  output logic           res_valid,
  output logic [N-1:0]   res_data,
  output logic [1:0]     err_code,
  input  logic           err_clr,
  output logic [depth:0] level,
  output logic           stk_wr_en,
  output logic           stk_rd_en,
  output logic [N-1:0]   stk_din,
  input  logic [N-1:0]   stk_dout,
  input  logic           stk_full,
  input  logic           stk_empty
);
  import rpn_pkg::*;

  localparam logic [depth:0] FULL_LVL = {1'b1, {depth{1'b0}}};
  localparam logic [depth:0] LVL_ONE  = {{depth{1'b0}}, 1'b1};

  state_t       state;
  logic [3:0]   op_reg;
  logic [N-1:0] b_reg;
  logic [N-1:0] alu_y;
  logic [3:0]   tok_op;

  assign tok_op    = tok_data[3:0];
  assign tok_ready = (state == IDLE) || (state == ERR);

  rpn_alu #(.N(N)) u_alu (
    .op (op_reg),
    .a  (stk_dout),
    .b  (b_reg),
    .y  (alu_y)
  );

  // Stack strobes are decoded combinationally so an operand push lands in its accept cycle.
  always_comb begin
    stk_wr_en = 1'b0;
    stk_rd_en = 1'b0;
    stk_din   = alu_y;
    case (state)
      IDLE: begin
        if (tok_valid) begin
          if (!tok_is_op) begin
            stk_wr_en = (level != FULL_LVL);
            stk_din   = tok_data;
          end else if (op_is_binary(tok_op)) begin
            stk_rd_en = (level > LVL_ONE);
          end else if (tok_op == OP_EQ) begin
            stk_rd_en = (level != '0);
          end
        end
      end
      POP_A:   stk_rd_en = 1'b1;
      EXEC:    stk_wr_en = 1'b1;
      FLUSH:   stk_rd_en = (level != '0);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      level     <= '0;
      err_code  <= ERR_NONE;
      res_valid <= 1'b0;
      res_data  <= '0;
      b_reg     <= '0;
      op_reg    <= '0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (tok_valid) begin
            if (!tok_is_op) begin
              if (level == FULL_LVL) begin
                err_code <= ERR_OVER;
                state    <= ERR;
              end else begin
                level <= level + LVL_ONE;
              end
            end else if (op_is_binary(tok_op)) begin
              if (level > LVL_ONE) begin
                op_reg <= tok_op;
                state  <= POP_A;
              end else begin
                err_code <= ERR_UNDER;
                state    <= ERR;
              end
            end else if (tok_op == OP_EQ) begin
              if (level != '0) begin
                state <= EQ_OUT;
              end else begin
                err_code <= ERR_UNDER;
                state    <= ERR;
              end
            end else begin
              err_code <= ERR_BADOP;
              state    <= ERR;
            end
          end
        end
        POP_A: begin
          b_reg <= stk_dout;
          state <= EXEC;
        end
        // Level is only adjusted here: two pops and one push net to -1.
        EXEC: begin
          level <= level - LVL_ONE;
          state <= IDLE;
        end
        EQ_OUT: begin
          res_valid <= 1'b1;
          res_data  <= stk_dout;
          level     <= level - LVL_ONE;
          state     <= IDLE;
        end
        ERR: begin
          if (err_clr) state <= FLUSH;
        end
        FLUSH: begin
          if (level != '0) begin
            level <= level - LVL_ONE;
          end else begin
            err_code <= ERR_NONE;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Mid-op the lifo runs ahead of level, so the mirror is only comparable at rest.
  a_level_mirror: assert property (@(posedge clk) disable iff (!reset_n)
    (state == IDLE) |-> ((stk_full == (level == FULL_LVL)) && (stk_empty == (level == '0))));

endmodule

// File: tb/tb_rpn_eval.sv
// Bench for rpn_eval with a behavioural 8-entry lifo; results checked through a scoreboard queue.
module tb_rpn_eval;
  localparam int N = 32;
  localparam int D = 3;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         tok_valid, tok_ready, tok_is_op;
  logic [N-1:0] tok_data;
  logic         res_valid;
  logic [N-1:0] res_data;
  logic [1:0]   err_code;
  logic         err_clr;
  logic [D:0]   level;
  logic         stk_wr_en, stk_rd_en;
  logic [N-1:0] stk_din, stk_dout;
  logic         stk_full, stk_empty;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int res_cnt = 0;
  logic both_seen = 1'b0;
  logic [N-1:0] exp_q[$];

  logic [N-1:0] lifo_mem [8];
  int           lifo_cnt;

  always #5 clk = ~clk;

  rpn_eval #(.N(N), .depth(D)) dut (
    .clk(clk), .reset_n(reset_n),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_is_op(tok_is_op), .tok_data(tok_data),
    .res_valid(res_valid), .res_data(res_data), .err_code(err_code), .err_clr(err_clr),
    .level(level), .stk_wr_en(stk_wr_en), .stk_rd_en(stk_rd_en), .stk_din(stk_din),
    .stk_dout(stk_dout), .stk_full(stk_full), .stk_empty(stk_empty)
  );

  // Behavioural lifo: registered pop data, valid the cycle after stk_rd_en.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lifo_cnt <= 0;
      stk_dout <= '0;
    end else if (stk_wr_en && lifo_cnt < 8) begin
      lifo_mem[lifo_cnt] <= stk_din;
      lifo_cnt <= lifo_cnt + 1;
    end else if (stk_rd_en && lifo_cnt > 0) begin
      stk_dout <= lifo_mem[lifo_cnt - 1];
      lifo_cnt <= lifo_cnt - 1;
    end
  end
  assign stk_full  = (lifo_cnt == 8);
  assign stk_empty = (lifo_cnt == 0);

  always @(posedge clk) begin
    if (reset_n) begin
      if (stk_wr_en) wr_cnt <= wr_cnt + 1;
      if (stk_rd_en) rd_cnt <= rd_cnt + 1;
      if (stk_wr_en && stk_rd_en) both_seen <= 1'b1;
    end
  end

  // Scoreboard: every result pulse must match the oldest expected EQ value.
  always @(negedge clk) begin
    if (res_valid) begin
      res_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL res_unexpected got=%h required=none", res_data);
      end else begin
        logic [N-1:0] e;
        e = exp_q.pop_front();
        if (res_data !== e) begin
          errors++;
          $display("FAIL res_data got=%h required=%h", res_data, e);
        end
      end
    end
  end

  task automatic send(input logic is_op, input logic [N-1:0] d);
    int t = 0;
    @(negedge clk);
    tok_valid = 1'b1;
    tok_is_op = is_op;
    tok_data  = d;
    #1;
    while (!tok_ready && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    checks++;
    if (!tok_ready) begin
      errors++;
      $display("FAIL send_timeout tok_ready=%b required=1", tok_ready);
    end
    @(posedge clk);
    #1;
    tok_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_err();
    int t = 0;
    @(negedge clk);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    while ((err_code !== 2'd0 || !tok_ready) && t < 50) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 50) begin
      errors++;
      $display("FAIL flush_timeout err_code=%0d required=0", err_code);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; tok_valid = 1'b0; tok_is_op = 1'b0; tok_data = '0; err_clr = 1'b0;
    idle(2);
    checks++;
    if (level !== 4'd0 || err_code !== 2'd0 || res_valid !== 1'b0 || res_data !== '0 ||
        stk_wr_en !== 1'b0 || stk_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_values level=%0d err=%0d rv=%b rd=%h wr=%b rde=%b required=all zero",
               level, err_code, res_valid, res_data, stk_wr_en, stk_rd_en);
    end
    reset_n = 1'b1;
    idle(1);
    checks++;
    if (tok_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got=%b required=1", tok_ready);
    end
  endtask

  task automatic test_sub();
    int r0 = res_cnt;
    send(0, 7); send(0, 5); send(1, 1);
    exp_q.push_back(32'd2);
    send(1, 6);
    idle(4);
    checks++;
    if (res_cnt - r0 !== 1 || level !== 4'd0 || err_code !== 2'd0) begin
      errors++;
      $display("FAIL sub_eq pulses=%0d level=%0d err=%0d required=1,0,0", res_cnt - r0, level, err_code);
    end
  endtask

  task automatic test_chain();
    int low = 0;
    send(0, 3); send(0, 4); send(1, 0);
    @(negedge clk);
    while (!tok_ready && low < 10) begin
      low++;
      @(negedge clk);
    end
    checks++;
    if (low !== 2) begin
      errors++;
      $display("FAIL op_busy cycles=%0d required=2", low);
    end
    send(0, 2); send(1, 4);
    exp_q.push_back(32'd5);
    send(1, 6);
    idle(4);
  endtask

  task automatic test_overflow();
    int w0, r0;
    for (int i = 0; i < 8; i++) send(0, 32'(i + 10));
    idle(1);
    w0 = wr_cnt;
    send(0, 99);
    idle(2);
    checks++;
    if (wr_cnt !== w0 || err_code !== 2'd2 || level !== 4'd8) begin
      errors++;
      $display("FAIL overflow wr=%0d err=%0d level=%0d required=0,2,8", wr_cnt - w0, err_code, level);
    end
    r0 = rd_cnt;
    clear_err();
    checks++;
    if (rd_cnt - r0 !== 8 || err_code !== 2'd0 || level !== 4'd0 || stk_empty !== 1'b1) begin
      errors++;
      $display("FAIL flush pops=%0d err=%0d level=%0d empty=%b required=8,0,0,1",
               rd_cnt - r0, err_code, level, stk_empty);
    end
  endtask

  task automatic test_underflow();
    int w0, r0;
    send(0, 1);
    idle(1);
    w0 = wr_cnt; r0 = rd_cnt;
    send(1, 0);
    idle(2);
    checks++;
    if (err_code !== 2'd1 || wr_cnt !== w0 || rd_cnt !== r0) begin
      errors++;
      $display("FAIL underflow err=%0d wr=%0d rd=%0d required=1,0,0", err_code, wr_cnt - w0, rd_cnt - r0);
    end
    send(0, 9);
    idle(2);
    checks++;
    if (wr_cnt !== w0 || level !== 4'd1 || err_code !== 2'd1) begin
      errors++;
      $display("FAIL err_discard wr=%0d level=%0d err=%0d required=0,1,1", wr_cnt - w0, level, err_code);
    end
    clear_err();
    checks++;
    if (level !== 4'd0 || stk_empty !== 1'b1) begin
      errors++;
      $display("FAIL underflow_flush level=%0d empty=%b required=0,1", level, stk_empty);
    end
  endtask

  task automatic test_badop();
    int w0, r0;
    send(0, 4);
    idle(1);
    w0 = wr_cnt; r0 = rd_cnt;
    send(1, 9);
    idle(2);
    checks++;
    if (err_code !== 2'd3 || wr_cnt !== w0 || rd_cnt !== r0 || level !== 4'd1) begin
      errors++;
      $display("FAIL badop err=%0d wr=%0d rd=%0d level=%0d required=3,0,0,1",
               err_code, wr_cnt - w0, rd_cnt - r0, level);
    end
    clear_err();
  endtask

  task automatic test_mul();
    send(0, 6); send(0, 7); send(1, 5);
`ifdef RPN_MUL_EN
    exp_q.push_back(32'd42);
    send(1, 6);
    idle(4);
    checks++;
    if (err_code !== 2'd0 || level !== 4'd0) begin
      errors++;
      $display("FAIL mul err=%0d level=%0d required=0,0", err_code, level);
    end
`else
    idle(2);
    checks++;
    if (err_code !== 2'd3 || level !== 4'd2) begin
      errors++;
      $display("FAIL mul_disabled err=%0d level=%0d required=3,2", err_code, level);
    end
    clear_err();
`endif
  endtask

  task automatic test_wrap_reset();
    send(0, 32'hFFFF_FFFF); send(0, 1); send(1, 0);
    exp_q.push_back(32'd0);
    send(1, 6);
    idle(4);
    send(0, 2); send(0, 3); send(1, 0);
    reset_n = 1'b0;
    #1;
    checks++;
    if (level !== 4'd0 || err_code !== 2'd0 || res_valid !== 1'b0 || res_data !== '0 ||
        stk_wr_en !== 1'b0 || stk_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset level=%0d err=%0d rv=%b rd=%h wr=%b rde=%b required=all zero",
               level, err_code, res_valid, res_data, stk_wr_en, stk_rd_en);
    end
    idle(1);
    reset_n = 1'b1;
    idle(1);
    checks++;
    if (tok_ready !== 1'b1 || level !== 4'd0 || stk_empty !== 1'b1) begin
      errors++;
      $display("FAIL post_reset ready=%b level=%0d empty=%b required=1,0,1", tok_ready, level, stk_empty);
    end
  endtask

  initial begin
    test_reset();
    test_sub();
    test_chain();
    test_overflow();
    test_underflow();
    test_badop();
    test_mul();
    test_wrap_reset();
    idle(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL results_missing pending=%0d required=0", exp_q.size());
    end
    checks++;
    if (both_seen !== 1'b0) begin
      errors++;
      $display("FAIL wr_rd_overlap seen=%b required=0", both_seen);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
